// File: rtl/ib_bridge_pkg.sv
// Shared types for the IB/UART byte bridge: byte width and the two handshake FSM state sets.
package ib_bridge_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_OFFER,
      TX_RELEASE
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_WAIT,
      RX_ACK,
      RX_DROP
   } rx_state_t;
endpackage

// File: rtl/ib_uart_bridge_if.sv
// Signal bundle between the bridge and its neighbours (uart_rx, uart_tx, ioexp, control).
interface ib_uart_bridge_if;
   import ib_bridge_pkg::*;

   logic [BYTE_W-1:0] urx_data;
   logic              urx_valid;
   logic              rts;
   logic [BYTE_W-1:0] ib_tx_data;
   logic              ib_tx_avail;
   logic              ib_tx_ack_n;
   logic [BYTE_W-1:0] ib_rx_data;
   logic              ib_rx_avail;
   logic              ib_rx_ack;
   logic [BYTE_W-1:0] utx_data;
   logic              utx_valid;
   logic              utx_ready;
   logic              cts;
   logic              loopback;
   logic              ovf_clr;
   logic              ovf_h2m;
   logic              ovf_m2h;
   logic              led;

   modport slave (
      input  urx_data, urx_valid, ib_tx_ack_n, ib_rx_data, ib_rx_avail,
             utx_ready, cts, loopback, ovf_clr,
      output rts, ib_tx_data, ib_tx_avail, ib_rx_ack, utx_data, utx_valid,
             ovf_h2m, ovf_m2h, led
   );

   modport master (
      output urx_data, urx_valid, ib_tx_ack_n, ib_rx_data, ib_rx_avail,
             utx_ready, cts, loopback, ovf_clr,
      input  rts, ib_tx_data, ib_tx_avail, ib_rx_ack, utx_data, utx_valid,
             ovf_h2m, ovf_m2h, led
   );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO with extra-bit pointers; reports drops and any push/pop activity.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   drop,
   output logic                   act
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         full;
   logic         do_push;
   logic         do_pop;

   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot, so push on full still lands
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign act     = do_push | do_pop;
   assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ib_uart_bridge.sv
// Buffered byte bridge between ioexp level handshakes and the UART pair, with rts
// hysteresis, loopback, sticky overflow flags and a stretched activity LED.
//
// state      | meaning
// TX_IDLE    | waiting for a byte in H2M
// TX_OFFER   | ib_tx_avail high, waiting for ib_tx_ack_n low
// TX_RELEASE | waiting for ib_tx_ack_n to return high
// RX_WAIT    | waiting for ib_rx_avail (parked here while in loopback)
// RX_ACK     | one-cycle ib_rx_ack pulse
// RX_DROP    | waiting for ioexp to drop ib_rx_avail
module ib_uart_bridge
   import ib_bridge_pkg::*;
#(
   parameter int H2M_DEPTH = 16,
   parameter int M2H_DEPTH = 16,
   parameter int RTS_STOP  = 12,
   parameter int RTS_GO    = 8,
   parameter int LED_HOLD  = 65536
) (
   input logic             clk,
   input logic             nrst,
   ib_uart_bridge_if.slave bus
);
   localparam int HCW = $clog2(H2M_DEPTH) + 1;
   localparam int MCW = $clog2(M2H_DEPTH) + 1;
   localparam int LCW = $clog2(LED_HOLD);
   localparam logic [HCW-1:0] RTS_STOP_C = HCW'(RTS_STOP);
   localparam logic [HCW-1:0] RTS_GO_C   = HCW'(RTS_GO);
   localparam logic [MCW-1:0] M2H_FULL_C = MCW'(M2H_DEPTH);
   localparam logic [LCW-1:0] LED_RELOAD = LCW'(LED_HOLD - 1);

   logic [BYTE_W-1:0] h2m_dout, m2h_dout, m2h_din, tx_data;
   logic [HCW-1:0]    h2m_count;
   logic [MCW-1:0]    m2h_count;
   logic              h2m_empty, h2m_drop, h2m_act, tx_pop;
   logic              m2h_empty, m2h_drop, m2h_act, m2h_push, m2h_pop, m2h_full;
   logic              rx_push, utx_valid, tx_avail, rx_ack, rts_q, ovf_h2m_q, ovf_m2h_q;
   logic [LCW-1:0]    led_cnt;
   tx_state_t         tx_state;
   rx_state_t         rx_state;

   sync_fifo #(.DEPTH(H2M_DEPTH), .W(BYTE_W)) u_h2m (
      .clk(clk), .nrst(nrst), .push(bus.urx_valid & ~bus.loopback), .din(bus.urx_data),
      .pop(tx_pop), .dout(h2m_dout), .empty(h2m_empty), .count(h2m_count),
      .drop(h2m_drop), .act(h2m_act)
   );

   sync_fifo #(.DEPTH(M2H_DEPTH), .W(BYTE_W)) u_m2h (
      .clk(clk), .nrst(nrst), .push(m2h_push), .din(m2h_din),
      .pop(m2h_pop), .dout(m2h_dout), .empty(m2h_empty), .count(m2h_count),
      .drop(m2h_drop), .act(m2h_act)
   );

   assign tx_pop    = (tx_state == TX_IDLE) & ~h2m_empty;
   assign m2h_full  = (m2h_count == M2H_FULL_C);
   // ioexp bytes are never dropped: a full M2H simply leaves the byte waiting in ioexp
   assign rx_push   = (rx_state == RX_WAIT) & bus.ib_rx_avail & ~bus.loopback & ~m2h_full;
   assign m2h_push  = bus.loopback ? bus.urx_valid : rx_push;
   assign m2h_din   = bus.loopback ? bus.urx_data  : bus.ib_rx_data;
   assign utx_valid = ~m2h_empty & ~bus.cts;
   assign m2h_pop   = utx_valid & bus.utx_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_state <= TX_IDLE;
         tx_data  <= '0;
         tx_avail <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: if (!h2m_empty) begin
               tx_data  <= h2m_dout;
               tx_avail <= 1'b1;
               tx_state <= TX_OFFER;
            end
            TX_OFFER: if (!bus.ib_tx_ack_n) begin
               tx_avail <= 1'b0;
               tx_state <= TX_RELEASE;
            end
            TX_RELEASE: if (bus.ib_tx_ack_n) tx_state <= TX_IDLE;
            default: begin
               tx_avail <= 1'b0;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_state <= RX_WAIT;
         rx_ack   <= 1'b0;
      end else begin
         case (rx_state)
            RX_WAIT: if (rx_push) begin
               rx_ack   <= 1'b1;
               rx_state <= RX_ACK;
            end
            RX_ACK: begin
               rx_ack   <= 1'b0;
               rx_state <= RX_DROP;
            end
            RX_DROP: if (!bus.ib_rx_avail) rx_state <= RX_WAIT;
            default: begin
               rx_ack   <= 1'b0;
               rx_state <= RX_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rts_q     <= 1'b0;
         ovf_h2m_q <= 1'b0;
         ovf_m2h_q <= 1'b0;
         led_cnt   <= '0;
      end else begin
         if (h2m_count >= RTS_STOP_C)    rts_q <= 1'b1;
         else if (h2m_count <= RTS_GO_C) rts_q <= 1'b0;

         if (h2m_drop)         ovf_h2m_q <= 1'b1;
         else if (bus.ovf_clr) ovf_h2m_q <= 1'b0;
         if (m2h_drop)         ovf_m2h_q <= 1'b1;
         else if (bus.ovf_clr) ovf_m2h_q <= 1'b0;

         if (h2m_act | m2h_act)  led_cnt <= LED_RELOAD;
         else if (led_cnt != '0) led_cnt <= led_cnt - LCW'(1);
      end
   end

   assign bus.rts         = rts_q;
   assign bus.ib_tx_data  = tx_data;
   assign bus.ib_tx_avail = tx_avail;
   assign bus.ib_rx_ack   = rx_ack;
   assign bus.utx_data    = m2h_dout;
   assign bus.utx_valid   = utx_valid;
   assign bus.ovf_h2m     = ovf_h2m_q;
   assign bus.ovf_m2h     = ovf_m2h_q;
   assign bus.led         = (led_cnt != '0);
endmodule
